// File: rtl/mult_result_fifo.sv
// Result buffer for the shift-add multiplier chain: FWFT FIFO plus
// in-flight credit tracking so every issued product has a guaranteed slot.
module mult_result_fifo #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           issue,
    input  logic           rdy_i,
    input  logic [N+M-1:0] acc_i,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N+M-1:0] res_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] inflight,
    output logic           issue_ok,
    output logic           ovf,
    input  logic           ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = N + M;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] CRED_LIM = (AW+2)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   inflight_q, inflight_d;
    logic          ovf_q, ovf_d;

    logic full, pop, push, drop;
    logic [AW+1:0] credit_sum;

    assign full       = (count_q == FULL_CNT);
    assign res_valid  = (count_q != '0);
    assign pop        = res_valid && res_ready;
    assign push       = rdy_i && (!full || pop);
    assign drop       = rdy_i && full && !pop;
    assign res_data   = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign inflight   = inflight_q;
    assign ovf        = ovf_q;
    // Widened sum so count + inflight cannot wrap before the compare.
    assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ok   = (credit_sum < CRED_LIM);

    always_comb begin
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        ovf_d      = ovf_q;

        if (push) begin
            mem_d[wr_ptr_q] = acc_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // A spurious rdy_i (nothing in flight) must not underflow.
        if (issue && !rdy_i) begin
            if (inflight_q != FULL_CNT) begin
                inflight_d = inflight_q + CNT_ONE;
            end
        end else if (rdy_i && !issue) begin
            if (inflight_q != '0) begin
                inflight_d = inflight_q - CNT_ONE;
            end
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mult_result_fifo.sv
// Directed bench for mult_result_fifo with N=M=4, DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mult_result_fifo;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue;
    logic       rdy_i;
    logic [7:0] acc_i;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] count;
    logic [2:0] inflight;
    logic       issue_ok;
    logic       ovf;
    logic       ovf_clr;

    int total = 0;
    int bad   = 0;

    mult_result_fifo #(.N(4), .M(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .issue(issue), .rdy_i(rdy_i),
        .acc_i(acc_i), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .count(count), .inflight(inflight),
        .issue_ok(issue_ok), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [7:0] exp_v;

        rst_n = 1'b0; issue = 1'b1; rdy_i = 1'b1; acc_i = 8'h55;
        res_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick(); tick();
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_count", count, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_issue_ok", issue_ok, 1);
        chk("rst_ovf", ovf, 0);
        issue = 1'b0; rdy_i = 1'b0; acc_i = 8'h00;
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", count, 0);

        // Single product 5*7 arriving M=4 edges after issue
        issue = 1'b1;
        tick();
        issue = 1'b0;
        chk("single_inflight", inflight, 1);
        tick(); tick(); tick();
        rdy_i = 1'b1; acc_i = 8'h23;
        tick();
        rdy_i = 1'b0;
        chk("single_count", count, 1);
        chk("single_valid", res_valid, 1);
        chk("single_data", res_data, 8'h23);
        chk("single_inflight0", inflight, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_pop_count", count, 0);
        chk("single_pop_valid", res_valid, 0);

        // Issue throttling
        n = 0;
        for (int i = 0; i < 8; i++) begin
            issue = issue_ok;
            if (issue_ok) n++;
            tick();
        end
        issue = 1'b0;
        chk("thr_issues", n, 4);
        chk("thr_inflight", inflight, 4);
        chk("thr_issue_ok", issue_ok, 0);
        for (int k = 1; k <= 4; k++) begin
            rdy_i = 1'b1; acc_i = 8'(k);
            tick();
        end
        rdy_i = 1'b0;
        chk("thr_count", count, 4);
        chk("thr_inflight0", inflight, 0);
        chk("thr_ok_full", issue_ok, 0);
        chk("thr_head", res_data, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("thr_pop_count", count, 3);
        chk("thr_ok_back", issue_ok, 1);
        for (int k = 2; k <= 4; k++) begin
            chk("thr_drain", res_data, 32'(k));
            res_ready = 1'b1;
            tick();
        end
        res_ready = 1'b0;
        chk("thr_empty", count, 0);

        // Wrap-around: push 1..10, pop from the third push on
        exp_v = 8'd1;
        for (int k = 1; k <= 10; k++) begin
            rdy_i = 1'b1; acc_i = 8'(k);
            res_ready = (k >= 3);
            if (k >= 3) begin
                chk("wrap_data", res_data, 32'(exp_v));
                exp_v++;
            end
            tick();
        end
        rdy_i = 1'b0;
        chk("wrap_count", count, 2);
        for (int k = 0; k < 2; k++) begin
            chk("wrap_tail", res_data, 32'(exp_v));
            exp_v++;
            tick();
        end
        res_ready = 1'b0;
        chk("wrap_empty", count, 0);
        chk("wrap_ovf", ovf, 0);
        chk("wrap_inflight", inflight, 0);

        // Full with simultaneous push and pop
        for (int k = 1; k <= 4; k++) begin
            rdy_i = 1'b1; acc_i = 8'(k * 8'h11);
            tick();
        end
        chk("full_count", count, 4);
        acc_i = 8'hAA; res_ready = 1'b1;
        chk("full_head", res_data, 8'h11);
        tick();
        res_ready = 1'b0;
        chk("full_pp_count", count, 4);
        chk("full_pp_ovf", ovf, 0);
        chk("full_pp_head", res_data, 8'h22);

        // Overflow and ovf_clr priority
        acc_i = 8'hBB;
        tick();
        chk("ovf_count", count, 4);
        chk("ovf_set", ovf, 1);
        ovf_clr = 1'b1; acc_i = 8'hCC;
        tick();
        chk("ovf_set_wins", ovf, 1);
        rdy_i = 1'b0;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        res_ready = 1'b1;
        chk("ovf_d0", res_data, 8'h22); tick();
        chk("ovf_d1", res_data, 8'h33); tick();
        chk("ovf_d2", res_data, 8'h44); tick();
        chk("ovf_d3", res_data, 8'hAA); tick();
        res_ready = 1'b0;
        chk("ovf_empty", count, 0);

        // Reset mid-operation discards everything
        rdy_i = 1'b1; acc_i = 8'h77; issue = 1'b1;
        tick();
        rdy_i = 1'b0; issue = 1'b0;
        chk("mid_count", count, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_inflight", inflight, 0);
        tick();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_result_fifo.md
Name: mult_result_fifo

Overview:
- Downstream stage of the shift-add multiplier chain. Consumes the final cell's rdy/accumulator output and buffers products in a small first-word-fall-through (FWFT) FIFO.
- Presents products to the consumer over a valid/ready handshake.
- The cell chain cannot stall, so the block also tracks in-flight operations and gives the issuer an issue_ok credit. Every issued product therefore has a guaranteed slot.

Parameters:
N, 4, multiplicand width; product width is N+M
M, 4, multiplier width; equals the chain depth in cells
DEPTH, 4, FIFO entries; power of two, at least 2
AW, $clog2(DEPTH), pointer width; localparam, derived, not overridable

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
issue  input  1  one-cycle pulse when an operation enters the first cell (first cell en)
rdy_i  input  1  rdy of the last cell; product valid this cycle
acc_i  input  N+M  mult_acci_o of the last cell
res_valid  output  1  FIFO non-empty; res_data valid
res_ready  input  1  consumer accepts res_data
res_data  output  N+M  head-of-FIFO product
count  output  AW+1  entries stored, 0..DEPTH
inflight  output  AW+1  operations issued but not yet received on rdy_i
issue_ok  output  1  issuing this cycle cannot overflow the FIFO
ovf  output  1  sticky: a product arrived while the FIFO was full
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (async, rst_n low): rd_ptr=0, wr_ptr=0, count=0, inflight=0, ovf=0.
  - Resulting outputs: res_valid=0, res_data=0, issue_ok=1.
  - Storage array is also cleared to 0.
  - Reset mid-operation discards all stored and in-flight products.
- Push: rdy_i=1 and (count<DEPTH or pop in the same cycle).
  - Writes acc_i to mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Pop: res_valid=1 and res_ready=1; rd_ptr increments and wraps.
  - res_ready while empty is ignored.
- FWFT timing:
  - res_data is mem[rd_ptr], read combinationally from the registered array.
  - A push at edge t gives res_valid=1 and the data visible after edge t (latency 1 cycle).
  - res_data is don't-care when res_valid=0. The bench checks it only when valid.
- count update: +1 on push only, -1 on pop only, unchanged on push and pop together (including when full).
- Full and push without pop: the product is dropped. ovf sets at the next edge; pointers and count are unchanged.
- ovf:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr clears it.
  - Remains set until cleared or reset.
- inflight update: +1 on issue only, -1 on rdy_i only, unchanged on both together.
  - rdy_i with inflight=0 (spurious) does not decrement. The product is still pushed normally.
  - inflight saturates at DEPTH; an issue while issue_ok=0 is a protocol violation, and ovf catches the resulting overflow.
- issue_ok is combinational: (count + inflight) < DEPTH.
  - Pops are not credited until the registered count updates (conservative).
  - Arithmetic is done at AW+2 bits to avoid wrap.
- Chain latency: an issue at edge t arrives on rdy_i at edge t+M. The block does not rely on this value; tracking is purely event-counted.
- All state is updated on the rising clk edge. There are no combinational paths from res_ready to res_valid.

Test Plan:
- Reset with rdy_i=1 and issue=1 held -> all outputs at reset values; issue_ok=1; no push until rst_n deasserts.
- Single product, N=M=4: issue, then rdy_i with acc_i=8'h23 (5*7) four cycles later, res_ready=0 -> count=1, res_valid=1, res_data=8'h23. Then res_ready=1 for one cycle -> count=0, res_valid=0.
- Issue throttling, DEPTH=4, res_ready=0: issue every cycle while issue_ok=1 -> exactly 4 issues, then issue_ok=0. After 4 rdy_i pulses: count=4, inflight=0. Popping one entry re-asserts issue_ok one cycle later.
- Wrap-around: 10 pushes of 1..10 interleaved with pops, keeping count ≤3 -> outputs appear in order 1..10; pointers wrap twice; ovf stays 0.
- Full plus simultaneous push/pop: count=4, rdy_i=1 with acc_i=8'hAA, res_ready=1 -> head popped, 8'hAA written, count stays 4, ovf=0.
- Overflow: count=4, rdy_i=1, res_ready=0 -> product dropped, count=4, ovf=1.
  - ovf_clr together with another overflow -> ovf remains 1.
  - ovf_clr alone -> ovf=0.
